gray_sync_decoder: RTL

Consumer stage for the 4-bit binary-to-Gray encoder output. It takes a Gray-coded value launched from another clock domain and passes it through a multi-flop synchronizer. It then converts the synchronized value back to binary and classifies each change as up, down or illegal. It sits on the receive side of pointer and position crossings and feeds binary values plus step events to downstream logic.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/sync_chain.sv | 36 +++
 rtl/gray_sync_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for clock-domain-crossing blocks.
// Contents:
//   GRAY_MAX_W  - widest Gray word any user of these helpers may carry
//   gray2bin    - Gray -> binary, for any width up to GRAY_MAX_W
//   bin2gray_f  - binary -> Gray, for any width up to GRAY_MAX_W
// Narrower words are zero-extended to GRAY_MAX_W before the call. The
// result is then truncated back to the original width. Leading zeros are
// preserved by both conversions, so the narrow result is exact.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 16;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray_f(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a bus that changes at most one bit at a time.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; clears every stage
//   d      - foreign-domain input, asynchronous to clk
//   q      - output of the last stage
// The stages contain no logic between them. This keeps the metastability
// resolution window intact.
module sync_chain #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else begin
      s_q[0] <= d;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        s_q[k] <= s_q[k-1];
      end
    end
  end

  assign q = s_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive-side stage for a Gray-coded pointer or position.
// Function:
//   - synchronizes the Gray word
//   - decodes it to binary
//   - classifies every change as up (+1), down (-1) or illegal
// Ports:
//   clk      - receive-domain clock
//   rst_n    - asynchronous active-low reset
//   gray_in  - Gray word from the foreign domain
//   bin_out  - registered binary of the synchronized word
//   valid    - set once the first synchronized sample has been loaded
//   step_up  - one-cycle pulse: value advanced by +1 (mod 2^WIDTH)
//   step_dn  - one-cycle pulse: value moved by -1 (mod 2^WIDTH)
//   err      - one-cycle pulse: value changed by anything other than +/-1
//   err_cnt  - saturating count of err pulses
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned      FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [WIDTH-1:0]  D_UP      = WIDTH'(1);
  localparam logic [WIDTH-1:0]  D_DN      = '1;

  logic [WIDTH-1:0]     gs;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     delta;

  logic [FILL_W-1:0]    fill_q,  fill_d;
  logic [WIDTH-1:0]     bin_q,   bin_d;
  logic                 valid_q, valid_d;
  logic                 up_q,    up_d;
  logic                 dn_q,    dn_d;
  logic                 err_q,   err_d;
  logic [ERR_CNT_W-1:0] cnt_q,   cnt_d;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_in),
    .q     (gs)
  );

  // bin_q always equals gray2bin of the previously synchronized word. A
  // separate prev-Gray register would carry the same information, so the
  // step is measured against bin_q directly.
  always_comb begin
    b     = WIDTH'(gray2bin(GRAY_MAX_W'(gs)));
    delta = b - bin_q;
  end

  always_comb begin
    fill_d  = fill_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (fill_q != FILL_DONE) begin
      // Synchronizer still holds reset zeros; outputs stay quiet.
      fill_d = fill_q + FILL_W'(1);
    end else if (!valid_q) begin
      // First load is silent: no previous value to compare against.
      valid_d = 1'b1;
      bin_d   = b;
    end else begin
      bin_d = b;
      if (delta == D_UP) begin
        up_d = 1'b1;
      end else if (delta == D_DN) begin
        dn_d = 1'b1;
      end else if (delta != '0) begin
        err_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + ERR_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fill_q  <= fill_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bin_out = bin_q;
  assign valid   = valid_q;
  assign step_up = up_q;
  assign step_dn = dn_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule
